trigger_monitor: RTL and testbench
==================================

// Module: trigger_monitor
// PURPOSE
//  Downstream consumer of the free-running up-counter's trigger_o. Detects each wrap event,
//  i.e. a 1->0 transition of trigger_i, and counts events in a saturating counter.
//  Measures the cycle interval between consecutive events and raises a level IRQ when a
//  programmable event threshold is reached.
//  Provides a req/ack snapshot port so a bus-side reader gets a coherent {count, period} pair.
// PARAMETERS
//  CNT_BITS     16  width of event counter, threshold and snapshot count
//  PERIOD_BITS  32  width of interval counter and last/snapshot period
// PORTS
//  clk_i          in   1            single clock
//  rstn_i         in   1            asynchronous active-low reset
//  trigger_i      in   1            from counter trigger_o, same clock domain, no synchroniser
//  en_i           in   1            1 = monitor enabled
//  clear_i        in   1            sync clear of counts/flags, 1-cycle pulse or level
//  threshold_i    in   CNT_BITS     IRQ threshold; 0 = IRQ never fires
//  irq_clr_i      in   1            acknowledge IRQ (leave ALERT)
//  snap_req_i     in   1            snapshot request, level
//  snap_ack_o     out  1            snapshot valid/ack
//  snap_cnt_o     out  CNT_BITS     captured event count
//  snap_period_o  out  PERIOD_BITS  captured last period
//  event_cnt_o    out  CNT_BITS     live event count
//  last_period_o  out  PERIOD_BITS  cycles between the two most recent events
//  irq_o          out  1            high while in ALERT
//  overflow_o     out  1            sticky: event counter saturated
// BEHAVIOUR
//  Reset: all outputs 0; prev_q = 1; state = DISABLED.
//  - prev_q <= trigger_i every cycle, regardless of en_i. Enabling never fakes an event.
//  - event = prev_q & ~trigger_i.
//  - All registered outputs update on the edge that samples the event, so they are
//    visible 1 cycle later.
//  FSM states: DISABLED, WAIT_FIRST, MEASURE, ALERT.
//  - DISABLED: counters hold. en_i=1 -> WAIT_FIRST.
//  - WAIT_FIRST: on event, cnt += 1, period_ctr <= 1, go to MEASURE.
//  - MEASURE: period_ctr += 1 each cycle, saturating at all-ones. On event:
//    - last_period <= period_ctr; period_ctr <= 1; cnt += 1.
//    - If threshold_i != 0 and new cnt == threshold_i -> ALERT.
//  - ALERT: behaves as MEASURE and keeps counting. irq_clr_i=1 -> MEASURE.
//    If irq_clr_i and an event arrive in the same cycle, the event is counted and the
//    state goes to MEASURE. The threshold is not re-checked that cycle.
//  - en_i=0 in any state -> DISABLED next cycle. Values hold; irq_o drops.
//  Counter and flag rules:
//  - cnt saturates at 2^CNT_BITS-1. An event arriving at max sets overflow_o (sticky).
//  - clear_i has priority over an event and over irq_clr_i:
//    - cnt, period_ctr, last_period and overflow are zeroed; any event that cycle is discarded.
//    - State -> WAIT_FIRST if en_i, else DISABLED.
//  - Threshold compare uses the post-increment value, so reaching the threshold gives
//    irq_o = 1 exactly 1 cycle after the threshold event.
//  - threshold_i changed below cnt: no IRQ until a clear.
//  Snapshot handshake (independent of FSM):
//  - snap_req_i=1 & snap_ack_o=0: capture cnt and last_period, set snap_ack_o next cycle.
//  - Capture takes pre-update values if an event occurs in the same cycle.
//  - snap_* hold while snap_ack_o=1.
//  - snap_ack_o stays 1 while snap_req_i=1 and drops the cycle after snap_req_i falls.
//  - A new request requires snap_ack_o=0 (4-phase).
//  - clear_i does not affect snap_* or snap_ack_o.
// STRUCTURE
//  trigger_monitor_pkg: typedef enum logic [1:0] mon_state_t {DISABLED, WAIT_FIRST,
//  MEASURE, ALERT}; localparam encodings.
//  Sub-module sat_counter #(W): synchronous clear, increment and load-one, saturating, with
//  an at_max flag. It is instantiated for cnt and for period_ctr.
//  Top level holds the edge detector, FSM, threshold compare and snapshot regs.
// TESTING (upstream counter COUNTER_BITS=4 drives trigger_i: low 1 cycle every 16)
//  1. en=1, thr=0, run 5 wraps -> event_cnt_o=1..5; last_period_o=16 after 2nd event;
//     irq_o never 1.
//  2. thr=3, run 3 wraps -> irq_o=1 one cycle after 3rd event. Pulse irq_clr_i ->
//     irq_o=0 next cycle; counting continues to 4.
//  3. CNT_BITS=2, 5 wraps -> event_cnt_o sticks at 3; overflow_o=1 after 4th event.
//  4. clear_i asserted in the same cycle as an event -> event_cnt_o=0,
//     last_period_o=0, state WAIT_FIRST; next wrap gives cnt=1.
//  5. snap_req_i rises in an event cycle with cnt=2 -> snap_cnt_o=2, ack next cycle;
//     cnt=3 live. Ack falls 1 cycle after req falls.
//  6. rstn_i low mid-MEASURE (cnt=4, irq=1) -> all outputs 0 asynchronously; after
//     release no event is counted until the next real 1->0 trigger edge.

Source files
------------

// File: rtl/trigger_monitor_pkg.sv
// Shared types for the trigger monitor: FSM state encoding and default widths.
package trigger_monitor_pkg;

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    ALERT      = 2'd3
  } mon_state_t;

  localparam int unsigned DEF_CNT_BITS    = 16;
  localparam int unsigned DEF_PERIOD_BITS = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sync clear, load-one and increment (priority in that order).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         load_one_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_d, cnt_q;

  assign at_max_o = &cnt_q;
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = {{(W-1){1'b0}}, 1'b1};
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trigger_monitor.sv
// Counts 1->0 edges of trigger_i, measures the interval between them, raises a level IRQ
// at a programmable count and offers a 4-phase req/ack snapshot of {count, period}.
module trigger_monitor
  import trigger_monitor_pkg::*;
#(
  parameter int unsigned CNT_BITS    = DEF_CNT_BITS,
  parameter int unsigned PERIOD_BITS = DEF_PERIOD_BITS
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   trigger_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [CNT_BITS-1:0]    threshold_i,
  input  logic                   irq_clr_i,
  input  logic                   snap_req_i,
  output logic                   snap_ack_o,
  output logic [CNT_BITS-1:0]    snap_cnt_o,
  output logic [PERIOD_BITS-1:0] snap_period_o,
  output logic [CNT_BITS-1:0]    event_cnt_o,
  output logic [PERIOD_BITS-1:0] last_period_o,
  output logic                   irq_o,
  output logic                   overflow_o
);

  mon_state_t state_d, state_q;
  logic prev_d, prev_q;
  logic overflow_d, overflow_q;
  logic [PERIOD_BITS-1:0] last_period_d, last_period_q;
  logic [PERIOD_BITS-1:0] period_cnt;
  logic [CNT_BITS-1:0] cnt, cnt_inc;
  logic cnt_at_max, per_at_max;
  logic snap_ack_d, snap_ack_q;
  logic [CNT_BITS-1:0] snap_cnt_d, snap_cnt_q;
  logic [PERIOD_BITS-1:0] snap_period_d, snap_period_q;

  logic evt, counting, in_measure, acc_evt;

  assign prev_d     = trigger_i;
  assign evt        = prev_q & ~trigger_i;
  assign counting   = en_i && (state_q != DISABLED);
  assign in_measure = (state_q == MEASURE) || (state_q == ALERT);
  // An event is only taken when the monitor is running and not being cleared.
  assign acc_evt    = counting && evt && !clear_i;
  assign cnt_inc    = cnt_at_max ? cnt : cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};

  sat_counter #(.W(CNT_BITS)) u_evt_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clear_i),
    .load_one_i (1'b0),
    .inc_i      (acc_evt),
    .cnt_o      (cnt),
    .at_max_o   (cnt_at_max)
  );

  sat_counter #(.W(PERIOD_BITS)) u_period_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clear_i),
    .load_one_i (acc_evt),
    .inc_i      (en_i && in_measure && !per_at_max),
    .cnt_o      (period_cnt),
    .at_max_o   (per_at_max)
  );

  always_comb begin
    overflow_d    = overflow_q;
    last_period_d = last_period_q;
    if (clear_i) begin
      overflow_d    = 1'b0;
      last_period_d = '0;
    end else if (acc_evt) begin
      if (cnt_at_max) overflow_d = 1'b1;
      if (in_measure) last_period_d = period_cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = DISABLED;
    end else if (clear_i) begin
      state_d = WAIT_FIRST;
    end else begin
      case (state_q)
        DISABLED:   state_d = WAIT_FIRST;
        WAIT_FIRST: if (evt) state_d = MEASURE;
        MEASURE:    if (evt && (threshold_i != '0) && (cnt_inc == threshold_i)) state_d = ALERT;
        ALERT:      if (irq_clr_i) state_d = MEASURE;
        default:    state_d = DISABLED;
      endcase
    end
  end

  // Snapshot captures the values before any same-cycle event update.
  always_comb begin
    snap_ack_d    = snap_ack_q;
    snap_cnt_d    = snap_cnt_q;
    snap_period_d = snap_period_q;
    if (snap_req_i && !snap_ack_q) begin
      snap_ack_d    = 1'b1;
      snap_cnt_d    = cnt;
      snap_period_d = last_period_q;
    end else if (!snap_req_i) begin
      snap_ack_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= DISABLED;
      prev_q        <= 1'b1;
      overflow_q    <= 1'b0;
      last_period_q <= '0;
      snap_ack_q    <= 1'b0;
      snap_cnt_q    <= '0;
      snap_period_q <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      overflow_q    <= overflow_d;
      last_period_q <= last_period_d;
      snap_ack_q    <= snap_ack_d;
      snap_cnt_q    <= snap_cnt_d;
      snap_period_q <= snap_period_d;
    end
  end

  assign event_cnt_o   = cnt;
  assign last_period_o = last_period_q;
  assign irq_o         = (state_q == ALERT);
  assign overflow_o    = overflow_q;
  assign snap_ack_o    = snap_ack_q;
  assign snap_cnt_o    = snap_cnt_q;
  assign snap_period_o = snap_period_q;

endmodule

// File: tb/tb_trigger_monitor.sv
// Directed bench: 16-cycle trigger wraps drive a 16-bit monitor and a 2-bit one in parallel.
module tb_trigger_monitor;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic trigger = 1'b1;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic [15:0] thr = '0;
  logic irq_clr = 1'b0;
  logic snap_req = 1'b0;

  logic        snap_ack;
  logic [15:0] snap_cnt;
  logic [31:0] snap_period;
  logic [15:0] event_cnt;
  logic [31:0] last_period;
  logic        irq;
  logic        overflow;

  logic        s_snap_ack;
  logic [1:0]  s_snap_cnt;
  logic [31:0] s_snap_period;
  logic [1:0]  s_event_cnt;
  logic [31:0] s_last_period;
  logic        s_irq;
  logic        s_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trigger_monitor #(.CNT_BITS(16), .PERIOD_BITS(32)) dut (
    .clk_i(clk), .rstn_i(rstn), .trigger_i(trigger), .en_i(en), .clear_i(clear),
    .threshold_i(thr), .irq_clr_i(irq_clr), .snap_req_i(snap_req),
    .snap_ack_o(snap_ack), .snap_cnt_o(snap_cnt), .snap_period_o(snap_period),
    .event_cnt_o(event_cnt), .last_period_o(last_period), .irq_o(irq),
    .overflow_o(overflow)
  );

  trigger_monitor #(.CNT_BITS(2), .PERIOD_BITS(32)) dut_small (
    .clk_i(clk), .rstn_i(rstn), .trigger_i(trigger), .en_i(en), .clear_i(clear),
    .threshold_i(2'b00), .irq_clr_i(irq_clr), .snap_req_i(1'b0),
    .snap_ack_o(s_snap_ack), .snap_cnt_o(s_snap_cnt), .snap_period_o(s_snap_period),
    .event_cnt_o(s_event_cnt), .last_period_o(s_last_period), .irq_o(s_irq),
    .overflow_o(s_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Trigger low for the single sampling edge; outputs are checkable on return.
  task automatic wrap();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    tick();
    n_cmp++;
    if ({event_cnt, last_period, irq, overflow, snap_ack, snap_cnt, snap_period} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: cnt=%0d per=%0d irq=%b ovf=%b ack=%b, required all 0",
               event_cnt, last_period, irq, overflow, snap_ack);
    end
  endtask

  task automatic test_count_period();
    logic irq_seen = 1'b0;
    en = 1'b1;
    thr = '0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      wrap();
      irq_seen |= irq;
      n_cmp++;
      if (event_cnt !== 16'(i)) begin
        n_bad++;
        $display("FAIL count_evt%0d: got %0d required %0d", i, event_cnt, i);
      end
      n_cmp++;
      if (last_period !== ((i == 1) ? 32'd0 : 32'd16)) begin
        n_bad++;
        $display("FAIL period_evt%0d: got %0d required %0d", i, last_period, (i == 1) ? 0 : 16);
      end
      for (int k = 0; k < 15; k++) begin
        tick();
        irq_seen |= irq;
      end
    end
    n_cmp++;
    if (irq_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_thr0: got %b required 0", irq_seen);
    end
  endtask

  task automatic test_threshold();
    do_clear();
    thr = 16'd3;
    for (int i = 1; i <= 3; i++) begin
      n_cmp++;
      if (irq !== 1'b0) begin
        n_bad++;
        $display("FAIL irq_before_evt%0d: got %b required 0", i, irq);
      end
      wrap();
      if (i < 3) idle(15);
    end
    n_cmp++;
    if (irq !== 1'b1 || event_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL irq_at_thr: irq=%b cnt=%0d required irq=1 cnt=3", irq, event_cnt);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_clr: got %b required 0", irq);
    end
    idle(14);
    wrap();
    n_cmp++;
    if (event_cnt !== 16'd4 || irq !== 1'b0 || last_period !== 32'd16) begin
      n_bad++;
      $display("FAIL after_clr: cnt=%0d irq=%b per=%0d required 4/0/16", event_cnt, irq, last_period);
    end
    thr = '0;
    idle(15);
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 1; i <= 5; i++) begin
      wrap();
      n_cmp++;
      if (s_event_cnt !== ((i > 3) ? 2'd3 : 2'(i)) || s_overflow !== (i >= 4)) begin
        n_bad++;
        $display("FAIL sat_evt%0d: cnt=%0d ovf=%b required %0d/%b", i, s_event_cnt, s_overflow,
                 (i > 3) ? 3 : i, (i >= 4));
      end
      idle(15);
    end
    n_cmp++;
    if (overflow !== 1'b0 || event_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL wide_no_ovf: ovf=%b cnt=%0d required 0/5", overflow, event_cnt);
    end
  endtask

  task automatic test_clear_event();
    trigger = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    trigger = 1'b1;
    n_cmp++;
    if (event_cnt !== 16'd0 || last_period !== 32'd0 || s_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_evt: cnt=%0d per=%0d sovf=%b required 0/0/0", event_cnt, last_period, s_overflow);
    end
    idle(15);
    wrap();
    n_cmp++;
    if (event_cnt !== 16'd1 || last_period !== 32'd0) begin
      n_bad++;
      $display("FAIL clear_next: cnt=%0d per=%0d required 1/0", event_cnt, last_period);
    end
    idle(15);
  endtask

  task automatic test_snapshot();
    do_clear();
    wrap();
    idle(15);
    wrap();
    idle(15);
    trigger = 1'b0;
    snap_req = 1'b1;
    tick();
    trigger = 1'b1;
    n_cmp++;
    if (snap_ack !== 1'b1 || snap_cnt !== 16'd2 || snap_period !== 32'd16 || event_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL snap_evt: ack=%b scnt=%0d sper=%0d cnt=%0d required 1/2/16/3",
               snap_ack, snap_cnt, snap_period, event_cnt);
    end
    idle(15);
    wrap();
    n_cmp++;
    if (snap_ack !== 1'b1 || snap_cnt !== 16'd2 || event_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL snap_hold: ack=%b scnt=%0d cnt=%0d required 1/2/4", snap_ack, snap_cnt, event_cnt);
    end
    snap_req = 1'b0;
    tick();
    n_cmp++;
    if (snap_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL snap_drop: ack=%b required 0", snap_ack);
    end
    snap_req = 1'b1;
    tick();
    n_cmp++;
    if (snap_ack !== 1'b1 || snap_cnt !== 16'd4 || snap_period !== 32'd16) begin
      n_bad++;
      $display("FAIL snap_again: ack=%b scnt=%0d sper=%0d required 1/4/16", snap_ack, snap_cnt, snap_period);
    end
    snap_req = 1'b0;
    idle(14);
  endtask

  task automatic test_async_reset();
    do_clear();
    thr = 16'd4;
    for (int i = 1; i <= 4; i++) begin
      wrap();
      if (i < 4) idle(15);
    end
    n_cmp++;
    if (irq !== 1'b1 || event_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL pre_reset: irq=%b cnt=%0d required 1/4", irq, event_cnt);
    end
    snap_req = 1'b1;
    tick();
    rstn = 1'b0;
    #2;
    n_cmp++;
    if ({event_cnt, last_period, irq, overflow, snap_ack, snap_cnt, snap_period} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: cnt=%0d per=%0d irq=%b ack=%b scnt=%0d required all 0",
               event_cnt, last_period, irq, snap_ack, snap_cnt);
    end
    snap_req = 1'b0;
    thr = '0;
    rstn = 1'b1;
    idle(3);
    n_cmp++;
    if (event_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL post_reset_idle: cnt=%0d required 0", event_cnt);
    end
    wrap();
    n_cmp++;
    if (event_cnt !== 16'd1 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_evt: cnt=%0d irq=%b required 1/0", event_cnt, irq);
    end
  endtask

  initial begin
    test_reset();
    test_count_period();
    test_threshold();
    test_saturate();
    test_clear_event();
    test_snapshot();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
